// File: rtl/adder_rr_scheduler.sv
// Round-robin scheduler sharing one registered WIDTH-bit adder among NUM_REQ requesters.
// Optional completed-response counter (perf_cnt) enabled by defining ADDER_RR_PERF_CNT_EN.
module adder_rr_scheduler #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_REQ-1:0]           req_valid,
   input  logic [NUM_REQ*WIDTH-1:0]     req_a,
   input  logic [NUM_REQ*WIDTH-1:0]     req_b,
   output logic [NUM_REQ-1:0]           req_ready,
   output logic                         resp_valid,
   input  logic                         resp_ready,
   output logic [$clog2(NUM_REQ)-1:0]   resp_id,
   output logic [WIDTH:0]               resp_sum,
   output logic                         busy
`ifdef ADDER_RR_PERF_CNT_EN
   ,
   output logic [15:0]                  perf_cnt
`endif
);

   // state | meaning
   // IDLE  | offering a grant to the first valid requester at or after ptr
   // EXEC  | operands latched; adder result registered into resp_sum
   // RESP  | response presented, held until resp_ready

   localparam int ID_W = $clog2(NUM_REQ);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t            state;
   logic [ID_W-1:0]   ptr;
   logic [WIDTH-1:0]  a_q;
   logic [WIDTH-1:0]  b_q;
   logic [ID_W-1:0]   id_q;

   logic [NUM_REQ-1:0] grant_oh;
   logic [ID_W-1:0]    grant_id;
   logic               grant_hit;
   int                 grant_idx;
   logic [WIDTH-1:0]   a_sel;
   logic [WIDTH-1:0]   b_sel;
   logic               handshake;

   // Wrap-around priority search starting at ptr.
   always_comb begin
      grant_oh  = '0;
      grant_id  = '0;
      grant_hit = 1'b0;
      grant_idx = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         grant_idx = int'(ptr) + k;
         if (grant_idx >= NUM_REQ) begin
            grant_idx = grant_idx - NUM_REQ;
         end
         if (!grant_hit && req_valid[grant_idx]) begin
            grant_hit = 1'b1;
            grant_id  = ID_W'(grant_idx);
         end
      end
      if (grant_hit) begin
         grant_oh[grant_id] = 1'b1;
      end
   end

   assign req_ready = (rst_n && (state == IDLE)) ? grant_oh : '0;
   assign handshake = |(req_valid & req_ready);
   assign a_sel     = req_a[grant_id*WIDTH +: WIDTH];
   assign b_sel     = req_b[grant_id*WIDTH +: WIDTH];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         ptr        <= '0;
         a_q        <= '0;
         b_q        <= '0;
         id_q       <= '0;
         resp_valid <= 1'b0;
         resp_id    <= '0;
         resp_sum   <= '0;
         busy       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (handshake) begin
                  a_q   <= a_sel;
                  b_q   <= b_sel;
                  id_q  <= grant_id;
                  busy  <= 1'b1;
                  state <= EXEC;
               end
            end
            EXEC: begin
               resp_sum   <= {1'b0, a_q} + {1'b0, b_q};
               resp_id    <= id_q;
               resp_valid <= 1'b1;
               state      <= RESP;
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  busy       <= 1'b0;
                  ptr        <= (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + ID_W'(1);
                  state      <= IDLE;
               end
            end
            default: begin
               resp_valid <= 1'b0;
               busy       <= 1'b0;
               state      <= IDLE;
            end
         endcase
      end
   end

`ifdef ADDER_RR_PERF_CNT_EN
   // Saturating count of accepted responses.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_cnt <= '0;
      end else if (resp_valid && resp_ready && (perf_cnt != 16'hFFFF)) begin
         perf_cnt <= perf_cnt + 16'd1;
      end
   end
`endif

   grant_onehot_a: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready));

   resp_hold_a: assert property (@(posedge clk) disable iff (!rst_n)
      (resp_valid && !resp_ready) |=> (resp_valid && $stable(resp_id) && $stable(resp_sum)));

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Self-checking bench for adder_rr_scheduler: per-cycle behavioural model plus directed literal checks.
// Define ADDER_RR_PERF_CNT_EN to also exercise perf_cnt.
module tb_adder_rr_scheduler;
   localparam int N = 4;
   localparam int W = 2;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   req_valid = '0;
   logic [N*W-1:0] req_a = '0;
   logic [N*W-1:0] req_b = '0;
   logic [N-1:0]   req_ready;
   logic           resp_valid;
   logic           resp_ready = 1'b0;
   logic [1:0]     resp_id;
   logic [W:0]     resp_sum;
   logic           busy;
`ifdef ADDER_RR_PERF_CNT_EN
   logic [15:0]    perf_cnt;
`endif

   adder_rr_scheduler #(.NUM_REQ(N), .WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_id    (resp_id),
      .resp_sum   (resp_sum),
      .busy       (busy)
`ifdef ADDER_RR_PERF_CNT_EN
      ,
      .perf_cnt   (perf_cnt)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;
   int cyc = 0;
   int rsp_ids[$];
   int rsp_cyc[$];

   always @(posedge clk) cyc = cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Model: phase counts progress of the single outstanding transaction
   // (0 = none, 1 = operands taken, 2 = response owed).
   int m_ph = 0, m_ptr = 0, m_id = 0, m_a = 0, m_b = 0;
   int m_oid = 0, m_osum = 0, m_cnt = 0;

   function automatic int first_from(input int p, input logic [N-1:0] v);
      for (int k = 0; k < N; k++) begin
         if (v[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   always @(negedge clk) begin
      logic [N-1:0] er;
      int g;
      g  = first_from(m_ptr, req_valid);
      er = '0;
      if (rst_n && m_ph == 0 && g >= 0) er[g] = 1'b1;
      if (chk_en) begin
         chk("req_ready", 32'(req_ready), 32'(er));
         chk("busy", 32'(busy), 32'(m_ph != 0));
         chk("resp_valid", 32'(resp_valid), 32'(m_ph == 2));
         chk("resp_id", 32'(resp_id), 32'(m_oid));
         chk("resp_sum", 32'(resp_sum), 32'(m_osum));
`ifdef ADDER_RR_PERF_CNT_EN
         chk("perf_cnt", 32'(perf_cnt), 32'(m_cnt));
`endif
      end
      if (rst_n && resp_valid && resp_ready) begin
         rsp_ids.push_back(int'(resp_id));
         rsp_cyc.push_back(cyc);
      end
      if (!rst_n) begin
         m_ph = 0; m_ptr = 0; m_oid = 0; m_osum = 0; m_cnt = 0;
      end else begin
         case (m_ph)
            0: if (g >= 0) begin
               m_id = g;
               m_a  = int'(req_a[g*W +: W]);
               m_b  = int'(req_b[g*W +: W]);
               m_ph = 1;
            end
            1: begin
               m_oid  = m_id;
               m_osum = m_a + m_b;
               m_ph   = 2;
            end
            default: if (resp_ready) begin
               m_ptr = (m_id + 1) % N;
               m_ph  = 0;
               if (m_cnt < 65535) m_cnt = m_cnt + 1;
            end
         endcase
      end
   end

   task automatic do_txn(input int id, input int a, input int b, input int exp_sum);
      req_valid = '0;
      req_valid[id] = 1'b1;
      req_a[id*W +: W] = W'(a);
      req_b[id*W +: W] = W'(b);
      resp_ready = 1'b1;
      tick();
      req_valid = '0;
      tick();
      chk("txn_valid", 32'(resp_valid), 32'd1);
      chk("txn_id", 32'(resp_id), 32'(id));
      chk("txn_sum", 32'(resp_sum), 32'(exp_sum));
      tick();
   endtask

   initial begin
      int sa[4];
      int sexp[4];
      int order[6];
      int n0;
      int guard;
      sa = '{0, 1, 2, 3};
      sexp = '{0, 2, 4, 6};
      order = '{0, 1, 2, 3, 0, 1};

      // Reset with all requesters asserting: grants must stay low.
      rst_n = 1'b0;
      req_valid = 4'hF;
      tick();
      chk_en = 1'b1;
      tick();
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_resp_sum", 32'(resp_sum), 32'd0);
      req_valid = '0;
      rst_n = 1'b1;
      tick();

      // Test 1: requester 0, 3+3.
      req_valid = 4'b0001;
      req_a[1:0] = 2'b11;
      req_b[1:0] = 2'b11;
      resp_ready = 1'b1;
      #1;
      chk("t1_grant", 32'(req_ready), 32'b0001);
      tick();
      req_valid = '0;
      chk("t1_exec_busy", 32'(busy), 32'd1);
      chk("t1_exec_nov", 32'(resp_valid), 32'd0);
      tick();
      chk("t1_valid", 32'(resp_valid), 32'd1);
      chk("t1_id", 32'(resp_id), 32'd0);
      chk("t1_sum", 32'(resp_sum), 32'b110);
      chk("t1_resp_busy", 32'(busy), 32'd1);
      tick();
      chk("t1_idle_busy", 32'(busy), 32'd0);

      // Test 2: sum sweep on requester 2.
      for (int i = 0; i < 4; i++) do_txn(2, sa[i], sa[i], sexp[i]);

      // Test 3: all requesters valid from ptr=0.
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      rsp_ids.delete();
      rsp_cyc.delete();
      req_a = 8'b11_10_01_00;
      req_b = 8'b01_11_10_00;
      req_valid = 4'hF;
      resp_ready = 1'b1;
      guard = 0;
      while (rsp_ids.size() < 6 && guard < 100) begin
         tick();
         guard++;
      end
      req_valid = '0;
      chk("t3_count", 32'(rsp_ids.size()), 32'd6);
      if (rsp_ids.size() >= 6) begin
         for (int i = 0; i < 6; i++) chk("t3_order", 32'(rsp_ids[i]), 32'(order[i]));
         for (int i = 1; i < 6; i++) chk("t3_interval", 32'(rsp_cyc[i] - rsp_cyc[i-1]), 32'd3);
      end
      repeat (4) tick();

      // Test 4: requester 1, 3+2, stalled 5 cycles in RESP.
      req_valid = 4'b0010;
      req_a[3:2] = 2'b11;
      req_b[3:2] = 2'b10;
      resp_ready = 1'b0;
      tick();
      req_valid = 4'hF;
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("t4_valid", 32'(resp_valid), 32'd1);
         chk("t4_id", 32'(resp_id), 32'd1);
         chk("t4_sum", 32'(resp_sum), 32'b101);
         chk("t4_ready", 32'(req_ready), 32'd0);
         tick();
      end
      req_valid = '0;
      resp_ready = 1'b1;
      tick();
      chk("t4_idle_busy", 32'(busy), 32'd0);
      chk("t4_idle_valid", 32'(resp_valid), 32'd0);

      // Test 5: reset during EXEC of requester 3.
      req_valid = 4'b1000;
      req_a[7:6] = 2'b10;
      req_b[7:6] = 2'b01;
      tick();
      chk("t5_exec_busy", 32'(busy), 32'd1);
      req_valid = '0;
      rst_n = 1'b0;
      n0 = rsp_ids.size();
      tick();
      rst_n = 1'b1;
      repeat (6) tick();
      chk("t5_no_resp", 32'(rsp_ids.size()), 32'(n0));
      chk("t5_valid", 32'(resp_valid), 32'd0);
      req_valid = 4'b1001;
      #1;
      chk("t5_grant", 32'(req_ready), 32'b0001);
      tick();
      req_valid = '0;
      tick();
      chk("t5_id", 32'(resp_id), 32'd0);
      tick();

`ifdef ADDER_RR_PERF_CNT_EN
      // Test 6: completed-response counter.
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("t6_rst", 32'(perf_cnt), 32'd0);
      for (int i = 0; i < 5; i++) do_txn(i % 4, 1, 2, 3);
      chk("t6_five", 32'(perf_cnt), 32'd5);
      resp_ready = 1'b0;
      req_valid = 4'b0001;
      tick();
      req_valid = '0;
      repeat (3) tick();
      chk("t6_stall", 32'(perf_cnt), 32'd5);
      resp_ready = 1'b1;
      tick();
      chk("t6_six", 32'(perf_cnt), 32'd6);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("t6_clear", 32'(perf_cnt), 32'd0);
      tick();
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1);
   end

endmodule
